// File: rtl/clk_en_gen_pkg.sv
// Shared constants and divisor helpers for the clk_en_gen multi-channel clock divider.
package clk_en_gen_pkg;

    localparam int unsigned CW_DEF          = 16;
    localparam int unsigned DEFAULT_DIV_DEF = 4;

    // A programmed divisor of 0 behaves as 1 (tick every cycle).
    function automatic int unsigned eff_div(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    // Number of high cycles of the square wave for period n.
    function automatic int unsigned half_up(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_en_gen_chan.sv
// One divider channel: counter, active divisor, single-entry pending divisor, tick and square wave.
module clk_en_chan
    import clk_en_gen_pkg::*;
#(
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_i,
    input  logic          wr_i,
    input  logic [CW-1:0] wr_val_i,
    output logic          pending_o,
    output logic          tick_o,
    output logic          clk_out_o
);

    localparam logic [CW-1:0] DIV_RST = CW'(eff_div(DEFAULT_DIV));

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] pend_val_q, pend_val_d;
    logic          pending_q, pending_d;
    logic          tick_q, tick_d;
    logic          clk_out_q, clk_out_d;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] half;
    logic          terminal;

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        tick_d     = 1'b0;
        clk_out_d  = clk_out_q;

        cnt_inc  = cnt_q + CW'(1);
        half     = CW'(half_up(32'(div_q)));
        terminal = (cnt_inc == div_q);

        if (sync_i) begin
            cnt_d     = '0;
            tick_d    = 1'b0;
            clk_out_d = 1'b0;
        end else if (terminal) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = 1'b1;
        end else begin
            cnt_d     = cnt_inc;
            tick_d    = 1'b0;
            clk_out_d = (cnt_inc < half);
        end

        // Uses pending_q, so a write accepted on this edge waits for the next boundary.
        if ((sync_i || terminal) && pending_q) begin
            div_d     = pend_val_q;
            pending_d = 1'b0;
        end

        if (wr_i) begin
            pend_val_d = CW'(eff_div(32'(wr_val_i)));
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
            clk_out_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
        end
    end

    assign pending_o = pending_q;
    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock-enable generator (tick + square wave per channel).
// Define CLK_EN_GEN_SYNC_EN to add the sync_i phase-alignment input.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter  int unsigned NCH         = 4,
    parameter  int unsigned CW          = CW_DEF,
    parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           div_valid,
    input  logic [CHW-1:0] div_ch,
    input  logic [CW-1:0]  div_value,
    output logic           div_ready,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] clk_out_o
`ifdef CLK_EN_GEN_SYNC_EN
    ,
    input  logic           sync_i
`endif
);

    logic           sync_w;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr;

`ifdef CLK_EN_GEN_SYNC_EN
    assign sync_w = sync_i;
`else
    assign sync_w = 1'b0;
`endif

    // Channel numbers >= NCH never match, so they read as not ready.
    always_comb begin
        div_ready = 1'b0;
        wr        = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (div_ch == CHW'(i)) begin
                div_ready = !pending[i];
                wr[i]     = div_valid && !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_en_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sync_i    (sync_w),
            .wr_i      (wr[g]),
            .wr_val_i  (div_value),
            .pending_o (pending[g]),
            .tick_o    (tick_o[g]),
            .clk_out_o (clk_out_o[g])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: directed scenarios plus random divisor writes vs. a timestamp model.
module tb_clk_en_gen;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 16;
    localparam int unsigned DDIV = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           div_valid;
    logic [1:0]     div_ch;
    logic [CW-1:0]  div_value;
    logic           div_ready;
    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] clk_out_o;
    logic           sync_i;

    // Three-channel instance so that an out-of-range channel number is representable.
    logic           d3_valid;
    logic [1:0]     d3_ch;
    logic [CW-1:0]  d3_value;
    logic           d3_ready;
    logic [2:0]     d3_tick;
    logic [2:0]     d3_clk;

    always #5 clk = ~clk;

    clk_en_gen #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DDIV)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_valid (div_valid),
        .div_ch    (div_ch),
        .div_value (div_value),
        .div_ready (div_ready),
        .tick_o    (tick_o),
        .clk_out_o (clk_out_o)
`ifdef CLK_EN_GEN_SYNC_EN
        ,
        .sync_i    (sync_i)
`endif
    );

    clk_en_gen #(.NCH(3), .CW(CW), .DEFAULT_DIV(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_valid (d3_valid),
        .div_ch    (d3_ch),
        .div_value (d3_value),
        .div_ready (d3_ready),
        .tick_o    (d3_tick),
        .clk_out_o (d3_clk)
`ifdef CLK_EN_GEN_SYNC_EN
        ,
        .sync_i    (1'b0)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: per channel, the edge number where the current period began and the period length.
    int unsigned    ecount;
    int unsigned    m_n    [NCH];
    int unsigned    m_last [NCH];
    int unsigned    m_pval [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int unsigned ch);
        return (ch < NCH) && !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_n[c]    = DDIV;
            m_last[c] = ecount;
            m_pend[c] = 1'b0;
            m_pval[c] = 0;
        end
        e_tick = '0;
        e_clk  = '0;
    endtask

    task automatic model_edge(input bit wr, input int unsigned ch, input int unsigned val, input bit s);
        int unsigned d;
        ecount++;
        for (int c = 0; c < NCH; c++) begin
            d = ecount - m_last[c];
            if (s || d == m_n[c]) begin
                e_tick[c] = !s;
                e_clk[c]  = !s;
                m_last[c] = ecount;
                if (m_pend[c]) begin
                    m_n[c]    = m_pval[c];
                    m_pend[c] = 1'b0;
                end
            end else begin
                e_tick[c] = 1'b0;
                e_clk[c]  = (d < (m_n[c] + 1) / 2);
            end
        end
        if (wr) begin
            m_pend[ch] = 1'b1;
            m_pval[ch] = (val == 0) ? 1 : val;
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic cycle(input bit v, input int unsigned ch, input int unsigned val, input bit s);
        bit acc;
        div_valid = v;
        div_ch    = ch[1:0];
        div_value = val[CW-1:0];
        sync_i    = s;
        #1;
        check_eq($sformatf("div_ready[ch%0d]", ch), {31'b0, div_ready}, {31'b0, m_ready(ch)});
        acc = v && m_ready(ch);
        @(posedge clk);
        #1;
        model_edge(acc, ch, val, s);
        check_eq("tick_o", {28'b0, tick_o}, {28'b0, e_tick});
        check_eq("clk_out_o", {28'b0, clk_out_o}, {28'b0, e_clk});
        div_valid = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic idle(input int unsigned n, input int unsigned ch);
        repeat (n) cycle(1'b0, ch, 0, 1'b0);
    endtask

    task automatic write_when_ready(input int unsigned ch, input int unsigned val);
        for (int i = 0; i < 64 && !m_ready(ch); i++) cycle(1'b0, ch, 0, 1'b0);
        cycle(1'b1, ch, val, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        div_valid = 1'b0;
        div_ch    = '0;
        div_value = '0;
        sync_i    = 1'b0;
        d3_valid  = 1'b0;
        d3_ch     = '0;
        d3_value  = '0;
        ecount    = 0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick", {28'b0, tick_o}, 32'd0);
        check_eq("rst_clk_out", {28'b0, clk_out_o}, 32'd0);
        check_eq("rst_d3_tick", {29'b0, d3_tick}, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Default divisor 4 on every channel: ticks on edges 4, 8, 12, clk_out 1100.
        idle(12, 0);

        // Out-of-range channel on the 3-channel instance is never ready and never writes.
        d3_valid = 1'b1;
        d3_ch    = 2'd3;
        d3_value = 16'd5;
        #1;
        check_eq("d3_ready_ch3", {31'b0, d3_ready}, 32'd0);
        idle(3, 0);
        d3_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            d3_ch = c[1:0];
            #1;
            check_eq($sformatf("d3_ready_ch%0d", c), {31'b0, d3_ready}, 32'd1);
        end

        // ch1 -> 3 mid-period.
        idle(1, 1);
        cycle(1'b1, 1, 3, 1'b0);
        idle(14, 1);

        // ch2 -> 0, 1, then 5.
        write_when_ready(2, 0);
        idle(6, 2);
        write_when_ready(2, 1);
        idle(6, 2);
        write_when_ready(2, 5);
        idle(14, 2);

        // ch0 -> 6 on its exact terminal-count edge; a second write while pending is refused.
        for (int i = 0; i < 20 && (ecount + 1 - m_last[0]) != m_n[0]; i++) cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b1, 0, 6, 1'b0);
        cycle(1'b1, 0, 7, 1'b0);
        idle(16, 0);

        // Reset pulse with a write pending on ch3.
        write_when_ready(3, 7);
        idle(2, 3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_pulse_tick", {28'b0, tick_o}, 32'd0);
        check_eq("rst_pulse_clk_out", {28'b0, clk_out_o}, 32'd0);
        check_eq("rst_pulse_ready", {31'b0, div_ready}, 32'd1);
        rst_n = 1'b1;
        model_reset();
        idle(12, 3);

`ifdef CLK_EN_GEN_SYNC_EN
        // Phase-align ch0 (4) and ch1 (8); ch3 pending 2 applies at the sync edge.
        write_when_ready(0, 4);
        write_when_ready(1, 8);
        for (int i = 0; i < 40 && (m_pend[0] || m_pend[1]); i++) cycle(1'b0, 0, 0, 1'b0);
        write_when_ready(3, 2);
        cycle(1'b1, 2, 3, 1'b1);
        idle(20, 0);
`endif

        for (int i = 0; i < 400; i++) begin
            bit s;
            s = 1'b0;
`ifdef CLK_EN_GEN_SYNC_EN
            s = ($urandom_range(0, 29) == 0);
`endif
            cycle(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 9), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
